lcd_write_arbiter: RTL

Round-robin arbiter that shares the single `lcd_write_cmd_data` I2C byte-writer among `NUM_REQ` requesters, such as `lcd_display` and a custom-character loader. It sits between the requesters and the writer in the `clk_1MHz` domain. It serialises one command/data byte at a time. A lock input lets a requester hold the writer across a multi-byte sequence, for example set-cursor followed by data bytes. A watchdog recovers the arbiter if the writer never reports completion.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/rr_picker.sv | 30 +++
 rtl/lcd_write_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: command/data select codes,
// arbiter state encoding and the default writer watchdog limit.
package lcd_pkg;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  localparam int unsigned LCD_TIMEOUT_CYC_DEFAULT = 20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } lcd_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester at or after last+1
// (mod NUM_REQ), as one-hot and index.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] win_c,
  output logic [IW-1:0]      win_idx_c,
  output logic               valid_c
);

  always_comb begin
    int j;
    j         = 0;
    win_c     = '0;
    win_idx_c = '0;
    valid_c   = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      j = (int'(last) + k) % int'(NUM_REQ);
      if (!valid_c && req[j]) begin
        valid_c    = 1'b1;
        win_c[j]   = 1'b1;
        win_idx_c  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD byte writer among NUM_REQ requesters,
// with per-requester lock for multi-byte sequences and a completion watchdog.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = LCD_TIMEOUT_CYC_DEFAULT
) (
  input  logic                   clk_1MHz,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     lock,
  input  logic [8*NUM_REQ-1:0]   data_in,
  input  logic [NUM_REQ-1:0]     cmd_data_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic                   timeout_flag,
  output logic [7:0]             data,
  output logic                   cmd_data,
  output logic                   ena_write,
  input  logic                   done_write
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lcd_arb_state_t       state, state_nxt;
  logic [IW-1:0]        last, last_nxt;
  logic [IW-1:0]        own, own_nxt;
  logic                 held, held_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, ack_nxt, err_nxt;
  logic                 timeout_nxt, cmd_data_nxt, ena_nxt;
  logic [7:0]           data_nxt;

  logic [NUM_REQ-1:0]   pick_c;
  logic [IW-1:0]        pick_idx_c;
  logic                 pick_valid_c;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req       (req),
    .last      (last),
    .win_c     (pick_c),
    .win_idx_c (pick_idx_c),
    .valid_c   (pick_valid_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    own_nxt      = own;
    held_nxt     = held;
    cnt_nxt      = cnt;
    grant_nxt    = grant;
    ack_nxt      = '0;
    err_nxt      = '0;
    timeout_nxt  = timeout_flag;
    data_nxt     = data;
    cmd_data_nxt = cmd_data;
    ena_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (held) begin
          if (!lock[own]) begin
            held_nxt  = 1'b0;
            grant_nxt = '0;
          end else if (req[own]) begin
            data_nxt     = data_in[{own, 3'b000} +: 8];
            cmd_data_nxt = cmd_data_in[own];
            state_nxt    = ISSUE;
          end
        end else if (pick_valid_c) begin
          grant_nxt    = pick_c;
          own_nxt      = pick_idx_c;
          last_nxt     = pick_idx_c;
          data_nxt     = data_in[{pick_idx_c, 3'b000} +: 8];
          cmd_data_nxt = cmd_data_in[pick_idx_c];
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        ena_nxt   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a coincident watchdog expiry.
        if (done_write) begin
          ack_nxt   = grant;
          state_nxt = ACK;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          err_nxt     = grant;
          timeout_nxt = 1'b1;
          grant_nxt   = '0;
          held_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ACK: begin
        state_nxt = IDLE;
        if (lock[own]) begin
          held_nxt = 1'b1;
        end else begin
          held_nxt  = 1'b0;
          grant_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= IW'(NUM_REQ - 1);
      own          <= '0;
      held         <= 1'b0;
      cnt          <= '0;
      grant        <= '0;
      ack          <= '0;
      err          <= '0;
      timeout_flag <= 1'b0;
      data         <= '0;
      cmd_data     <= LCD_CMD;
      ena_write    <= 1'b0;
    end else begin
      state        <= state_nxt;
      last         <= last_nxt;
      own          <= own_nxt;
      held         <= held_nxt;
      cnt          <= cnt_nxt;
      grant        <= grant_nxt;
      ack          <= ack_nxt;
      err          <= err_nxt;
      timeout_flag <= timeout_nxt;
      data         <= data_nxt;
      cmd_data     <= cmd_data_nxt;
      ena_write    <= ena_nxt;
    end
  end

endmodule
